reversi_board_fsm: RTL
======================

Name: reversi_board_fsm

Overview:
- Parametrised Reversi/Othello board engine for an N×N board; the board size is set by a parameter.
- Holds board state and whose turn it is. On each move request it checks that the move is legal, walks all 8 directions, flips bracketed stones, places the stone and hands the turn to the other player.
- Sits between the cursor/input controller (supplies x, y, go) and the VGA draw logic (reads board_result, player_black).

Parameters:
- N, 8, board edge length; even, 4..16.
- CW, $clog2(N), coordinate width; derived, do not override.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous, active-low reset
- x  input  CW  column of requested move
- y  input  CW  row of requested move
- go  input  1  move request; sampled only in IDLE
- new_game  input  1  synchronous restart to the initial board; sampled only in IDLE
- board_result  output  2*N*N  committed board
- player_black  output  1  1 = black to move
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse at the end of every move attempt
- legal  output  1  result of the last attempt; valid from the done pulse until the next done
- flips  output  CW+3  stones flipped by the last move

Behaviour:
- Cell (x,y) occupies bits [2*(y*N+x)+1 : 2*(y*N+x)].
- Cell encoding: 00 = empty, 10 = white, 11 = black. 01 is reserved and treated as empty.
- Initial board:
  - (N/2-1, N/2-1) and (N/2, N/2) are white.
  - (N/2, N/2-1) and (N/2-1, N/2) are black.
  - All other cells are empty.
- Reset (resetn=0, asynchronous) sets: initial board, player_black=1, busy=0, done=0, legal=0, flips=0, state IDLE, working board = board_result.
- Reset asserted mid-move aborts the move with no partial update.
- new_game in IDLE gives the same values as reset on the next edge. new_game has priority over go.
- FSM states: IDLE, CHECK, WALK, FLIP, NEXTDIR, COMMIT, DONE.
  - IDLE: when go=1, latch x, y and player into internal registers, clear the flip counter, go to CHECK. Later changes on x, y, go have no effect until the next IDLE.
  - CHECK: if the target cell is non-empty, go to DONE with legal=0. Otherwise set d=0 and go to WALK.
  - WALK: one cell per cycle from the target along direction d. Order: N, NE, E, SE, S, SW, W, NW. Track step count k.
    - Opponent cell: k++, continue.
    - Own cell with k>=1: go to FLIP.
    - Empty cell, off-board (coordinate wrap detected before any access), or own cell with k=0: go to NEXTDIR.
  - FLIP: one cell per cycle, walk back toward the target, setting each of the k cells to the mover's colour. Add k to the flip counter, then go to NEXTDIR.
  - NEXTDIR: d++. If d==8, go to COMMIT; else go to WALK.
  - COMMIT:
    - Flip counter 0: legal=0, working board restored from board_result.
    - Flip counter >0: place the stone, copy the working board to board_result, toggle player_black, legal=1.
    - Then go to DONE.
  - DONE: assert done for one cycle, update flips and legal, return to IDLE. busy drops in the same cycle as done.
- board_result changes only in COMMIT, so it is never seen half-flipped.
- go held high issues one move per IDLE visit. go during busy is ignored; it is not queued.
- Latency:
  - Occupied target: done 3 cycles after the go edge.
  - Worst case bounded by 3 + 8*(2N) cycles.
- No automatic pass. An illegal attempt leaves the board and player unchanged.

Optional Feature:
- Macro: REVERSI_SCORE_EN.
- Defined:
  - Adds outputs black_count and white_count, each 2*CW+1 bits.
  - Reset and new_game set both to 2.
  - In COMMIT of a legal move: mover count += flips+1, opponent count -= flips. Both update together with board_result.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, N=8 -> board_result has (3,3)=10, (4,4)=10, (4,3)=11, (3,4)=11, all else 00; player_black=1, busy=0, done=0.
- go at x=3,y=2 (black) -> done pulse, legal=1, flips=1, (3,2)=11, (3,3)=11, player_black=0; with REVERSI_SCORE_EN black_count=4, white_count=1.
- go at x=0,y=0 from the initial board -> legal=0, flips=0, board_result and player_black unchanged.
- go at x=3,y=3 (occupied) -> done exactly 3 cycles after the go edge, legal=0.
- Pulse go with a new x,y while busy -> ignored: single done, result matches the first request only.
- Drop resetn mid-WALK during a legal move -> outputs return to reset values immediately; no stone placed after release.

Source files
------------

// File: rtl/reversi_board_fsm.sv
// Reversi/Othello board engine: validates a move, flips bracketed stones in all eight
// directions and commits the board atomically. Define REVERSI_SCORE_EN to add stone counters.
module reversi_board_fsm #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [CW-1:0]    x,
    input  logic [CW-1:0]    y,
    input  logic             go,
    input  logic             new_game,
    output logic [2*N*N-1:0] board_result,
    output logic             player_black,
    output logic             busy,
    output logic             done,
    output logic             legal,
    output logic [CW+2:0]    flips
`ifdef REVERSI_SCORE_EN
    ,
    output logic [2*CW:0]    black_count,
    output logic [2*CW:0]    white_count
`endif
);

    localparam int BW = 2 * N * N;
    localparam int FW = CW + 3;
    localparam int SW = 2 * CW + 1;

    localparam logic [1:0] WHITE = 2'b10;
    localparam logic [1:0] BLACK = 2'b11;

    localparam logic [CW-1:0] ONE_C = 1;
    localparam logic [CW:0]   ONE_W = 1;
    localparam logic [CW:0]   N_W   = (CW + 1)'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WALK,
        S_FLIP,
        S_NEXTDIR,
        S_COMMIT,
        S_DONE
    } state_t;

    function automatic logic [BW-1:0] init_board();
        logic [BW-1:0] b;
        b = '0;
        b[2*((N/2-1)*N + (N/2-1)) +: 2] = WHITE;
        b[2*((N/2)*N + (N/2)) +: 2]     = WHITE;
        b[2*((N/2-1)*N + (N/2)) +: 2]   = BLACK;
        b[2*((N/2)*N + (N/2-1)) +: 2]   = BLACK;
        return b;
    endfunction

    localparam logic [BW-1:0] INIT_BOARD = init_board();

    function automatic int cell_idx(logic [CW-1:0] cx, logic [CW-1:0] cy);
        return 2 * (int'(cy) * N + int'(cx));
    endfunction

    state_t        state_q, state_d;
    logic [BW-1:0] board_q, board_d;
    logic [BW-1:0] work_q, work_d;
    logic          player_q, player_d;
    logic          mover_q, mover_d;
    logic [CW-1:0] tx_q, tx_d, ty_q, ty_d;
    logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [2:0]    d_q, d_d;
    logic [CW-1:0] k_q, k_d;
    logic [FW-1:0] flipcnt_q, flipcnt_d;
    logic          legal_pend_q, legal_pend_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          legal_q, legal_d;
    logic [FW-1:0] flips_q, flips_d;
`ifdef REVERSI_SCORE_EN
    logic [SW-1:0] black_cnt_q, black_cnt_d;
    logic [SW-1:0] white_cnt_q, white_cnt_d;
`endif

    logic          dx_inc, dx_dec, dy_inc, dy_dec;
    logic [CW:0]   fwd_x, fwd_y;
    logic [CW-1:0] bck_x, bck_y;
    logic          off_board;
    logic [1:0]    cell_fwd;
    logic [1:0]    mover_col, opp_col;
    logic [BW-1:0] placed;

    // Direction order N, NE, E, SE, S, SW, W, NW; y grows downward.
    always_comb begin
        {dx_inc, dx_dec, dy_inc, dy_dec} = 4'b0000;
        case (d_q)
            3'd0:    {dx_inc, dx_dec, dy_inc, dy_dec} = 4'b0001;
            3'd1:    {dx_inc, dx_dec, dy_inc, dy_dec} = 4'b1001;
            3'd2:    {dx_inc, dx_dec, dy_inc, dy_dec} = 4'b1000;
            3'd3:    {dx_inc, dx_dec, dy_inc, dy_dec} = 4'b1010;
            3'd4:    {dx_inc, dx_dec, dy_inc, dy_dec} = 4'b0010;
            3'd5:    {dx_inc, dx_dec, dy_inc, dy_dec} = 4'b0110;
            3'd6:    {dx_inc, dx_dec, dy_inc, dy_dec} = 4'b0100;
            default: {dx_inc, dx_dec, dy_inc, dy_dec} = 4'b0101;
        endcase
    end

    // One extra bit makes a step past either edge land at >= N, caught before any access.
    always_comb begin
        fwd_x = {1'b0, cx_q} + (dx_inc ? ONE_W : '0) - (dx_dec ? ONE_W : '0);
        fwd_y = {1'b0, cy_q} + (dy_inc ? ONE_W : '0) - (dy_dec ? ONE_W : '0);
        bck_x = cx_q - (dx_inc ? ONE_C : '0) + (dx_dec ? ONE_C : '0);
        bck_y = cy_q - (dy_inc ? ONE_C : '0) + (dy_dec ? ONE_C : '0);
        off_board = (fwd_x >= N_W) || (fwd_y >= N_W);
        cell_fwd  = work_q[cell_idx(fwd_x[CW-1:0], fwd_y[CW-1:0]) +: 2];
        mover_col = mover_q ? BLACK : WHITE;
        opp_col   = mover_q ? WHITE : BLACK;
    end

    always_comb begin
        // NOTE: every _d takes its _q value first, so no branch can leave a latch behind.
        state_d      = state_q;
        board_d      = board_q;
        work_d       = work_q;
        player_d     = player_q;
        mover_d      = mover_q;
        tx_d         = tx_q;
        ty_d         = ty_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        d_d          = d_q;
        k_d          = k_q;
        flipcnt_d    = flipcnt_q;
        legal_pend_d = legal_pend_q;
        legal_d      = legal_q;
        flips_d      = flips_q;
        done_d       = 1'b0;
        placed       = work_q;
`ifdef REVERSI_SCORE_EN
        black_cnt_d  = black_cnt_q;
        white_cnt_d  = white_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (new_game) begin
                    board_d      = INIT_BOARD;
                    work_d       = INIT_BOARD;
                    player_d     = 1'b1;
                    legal_d      = 1'b0;
                    flips_d      = '0;
                    legal_pend_d = 1'b0;
`ifdef REVERSI_SCORE_EN
                    black_cnt_d  = SW'(2);
                    white_cnt_d  = SW'(2);
`endif
                end else if (go) begin
                    tx_d      = x;
                    ty_d      = y;
                    mover_d   = player_q;
                    flipcnt_d = '0;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                // Bit 1 set means white or black; the reserved code 01 counts as empty.
                if (work_q[cell_idx(tx_q, ty_q) + 1]) begin
                    legal_pend_d = 1'b0;
                    state_d      = S_DONE;
                end else begin
                    d_d     = '0;
                    k_d     = '0;
                    cx_d    = tx_q;
                    cy_d    = ty_q;
                    state_d = S_WALK;
                end
            end
            S_WALK: begin
                if (off_board) begin
                    state_d = S_NEXTDIR;
                end else if (cell_fwd == opp_col) begin
                    k_d  = k_q + ONE_C;
                    cx_d = fwd_x[CW-1:0];
                    cy_d = fwd_y[CW-1:0];
                end else if (cell_fwd == mover_col && k_q != '0) begin
                    state_d = S_FLIP;
                end else begin
                    state_d = S_NEXTDIR;
                end
            end
            S_FLIP: begin
                work_d[cell_idx(cx_q, cy_q) +: 2] = mover_col;
                if (bck_x == tx_q && bck_y == ty_q) begin
                    flipcnt_d = flipcnt_q + FW'(k_q);
                    state_d   = S_NEXTDIR;
                end else begin
                    cx_d = bck_x;
                    cy_d = bck_y;
                end
            end
            S_NEXTDIR: begin
                d_d     = d_q + 3'd1;
                k_d     = '0;
                cx_d    = tx_q;
                cy_d    = ty_q;
                state_d = (d_q == 3'd7) ? S_COMMIT : S_WALK;
            end
            S_COMMIT: begin
                if (flipcnt_q == '0) begin
                    work_d       = board_q;
                    legal_pend_d = 1'b0;
                end else begin
                    placed[cell_idx(tx_q, ty_q) +: 2] = mover_col;
                    work_d       = placed;
                    board_d      = placed;
                    player_d     = ~player_q;
                    legal_pend_d = 1'b1;
`ifdef REVERSI_SCORE_EN
                    if (mover_q) begin
                        black_cnt_d = black_cnt_q + SW'(flipcnt_q) + SW'(1);
                        white_cnt_d = white_cnt_q - SW'(flipcnt_q);
                    end else begin
                        white_cnt_d = white_cnt_q + SW'(flipcnt_q) + SW'(1);
                        black_cnt_d = black_cnt_q - SW'(flipcnt_q);
                    end
`endif
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                legal_d = legal_pend_q;
                flips_d = flipcnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the board is a flop vector rather than a RAM, so it can and must take its reset value.
            state_q      <= S_IDLE;
            board_q      <= INIT_BOARD;
            work_q       <= INIT_BOARD;
            player_q     <= 1'b1;
            mover_q      <= 1'b1;
            tx_q         <= '0;
            ty_q         <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            d_q          <= '0;
            k_q          <= '0;
            flipcnt_q    <= '0;
            legal_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            legal_q      <= 1'b0;
            flips_q      <= '0;
`ifdef REVERSI_SCORE_EN
            black_cnt_q  <= SW'(2);
            white_cnt_q  <= SW'(2);
`endif
        end else begin
            // NOTE: non-blocking updates so every flop sees the pre-edge values of the others.
            state_q      <= state_d;
            board_q      <= board_d;
            work_q       <= work_d;
            player_q     <= player_d;
            mover_q      <= mover_d;
            tx_q         <= tx_d;
            ty_q         <= ty_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            d_q          <= d_d;
            k_q          <= k_d;
            flipcnt_q    <= flipcnt_d;
            legal_pend_q <= legal_pend_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            legal_q      <= legal_d;
            flips_q      <= flips_d;
`ifdef REVERSI_SCORE_EN
            black_cnt_q  <= black_cnt_d;
            white_cnt_q  <= white_cnt_d;
`endif
        end
    end

    assign board_result = board_q;
    assign player_black = player_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign legal        = legal_q;
    assign flips        = flips_q;
`ifdef REVERSI_SCORE_EN
    assign black_count  = black_cnt_q;
    assign white_count  = white_cnt_q;
`endif

endmodule
